mem_lsu: RTL and testbench

// Load/store initiator that drives the word-only data memory's read and write ports on behalf of the CPU.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lsu_align.sv | 42 ++++
 rtl/mem_lsu.sv | 156 +++++++++++++++
 tb/tb_mem_lsu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states, data width.
package mem_pkg;

  localparam int DATAWIDTH = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_RD     = 3'd1,
    LSU_RMW_RD = 3'd2,
    LSU_WR     = 3'd3,
    LSU_RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Little-endian lane handling: extract/extend a loaded byte or half, and merge store data into an old word.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]           lane,
  input  logic [1:0]           size,
  input  logic                 uns,
  input  logic [DATAWIDTH-1:0] rd_word,
  input  logic [DATAWIDTH-1:0] old_word,
  input  logic [DATAWIDTH-1:0] st_data,
  output logic [DATAWIDTH-1:0] ld_data,
  output logic [DATAWIDTH-1:0] st_word
);

  logic [4:0]           sh_amt;
  logic [DATAWIDTH-1:0] shifted;
  logic [DATAWIDTH-1:0] mask;

  // Halves only ever sit at lane 0 or 2, so the byte shift also positions them.
  assign sh_amt  = {lane, 3'b000};
  assign shifted = rd_word >> sh_amt;

  always_comb begin
    ld_data = shifted;
    case (size)
      SZ_B:    ld_data = uns ? {24'h0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data = uns ? {16'h0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    mask = '1;
    case (size)
      SZ_B:    mask = 32'h0000_00FF << sh_amt;
      SZ_H:    mask = 32'h0000_FFFF << sh_amt;
      default: mask = '1;
    endcase
    st_word = (old_word & ~mask) | ((st_data << sh_amt) & mask);
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the word-only data memory: sub-word loads with extension, sub-word stores as RMW.
// Handshakes: a beat transfers on the rising edge where valid & ready are both high; valid never waits on ready.
module mem_lsu
  import mem_pkg::*;
#(
  parameter  int NUMWORDS = 4096,
  localparam int WAW      = $clog2(NUMWORDS) + 1,
  localparam int BAW      = WAW + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [BAW-1:0]       req_addr_i,
  input  logic [DATAWIDTH-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DATAWIDTH-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 mem_re_o,
  output logic [WAW-1:0]       mem_raddr_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  output logic                 mem_we_o,
  output logic [WAW-1:0]       mem_waddr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  output logic [2:0]           state_o
);

  localparam logic [WAW-1:0] NW = WAW'(NUMWORDS);

  lsu_state_e           state;
  logic                 we_q, uns_q, err_q;
  logic [1:0]           size_q;
  logic [BAW-1:0]       addr_q;
  logic [DATAWIDTH-1:0] wdata_q, merge_q, rdata_q;
  logic                 req_ready_q, resp_valid_q, mem_re_q, mem_we_q;
  logic [WAW-1:0]       widx_q, req_widx;
  logic                 req_err;
  logic [DATAWIDTH-1:0] ld_data, st_word;

  assign widx_q   = addr_q[BAW-1:2];
  assign req_widx = req_addr_i[BAW-1:2];

  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      SZ_H:    req_err = req_addr_i[0];
      SZ_W:    req_err = |req_addr_i[1:0];
      SZ_X:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_widx >= NW) req_err = 1'b1;
  end

  mem_lsu_align u_align (
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .uns      (uns_q),
    .rd_word  (mem_rdata_i),
    .old_word (merge_q),
    .st_data  (wdata_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= LSU_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            rdata_q     <= '0;
            req_ready_q <= 1'b0;
            if (req_err) begin
              err_q        <= 1'b1;
              resp_valid_q <= 1'b1;
              state        <= LSU_RESP;
            end else if (!req_we_i) begin
              mem_re_q <= 1'b1;
              state    <= LSU_RD;
            end else if (req_size_i == SZ_W) begin
              mem_we_q <= 1'b1;
              state    <= LSU_WR;
            end else begin
              mem_re_q <= 1'b1;
              state    <= LSU_RMW_RD;
            end
          end
        end
        LSU_RD: begin
          rdata_q      <= ld_data;
          mem_re_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= LSU_RESP;
        end
        LSU_RMW_RD: begin
          merge_q  <= mem_rdata_i;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b1;
          state    <= LSU_WR;
        end
        LSU_WR: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= LSU_RESP;
        end
        LSU_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  // Word stores reach WR with merge_q stale; the all-ones mask makes the merge pass wdata through.
  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_re_o     = mem_re_q;
  assign mem_we_o     = mem_we_q;
  assign mem_raddr_o  = mem_re_q ? widx_q : '0;
  assign mem_waddr_o  = mem_we_q ? widx_q : '0;
  assign mem_wdata_o  = mem_we_q ? st_word : '0;
  assign state_o      = state;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu behind a 16-word behavioural memory, plus a short random run against a model.
module tb_mem_lsu;
  import mem_pkg::*;

  localparam int NW  = 16;
  localparam int WAW = 5;
  localparam int BAW = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]      req_size;
  logic [BAW-1:0]  req_addr;
  logic [31:0]     req_wdata;
  logic            resp_valid, resp_ready, resp_err;
  logic [31:0]     resp_rdata;
  logic            mem_re, mem_we;
  logic [WAW-1:0]  mem_raddr, mem_waddr;
  logic [31:0]     mem_rdata, mem_wdata;
  logic [2:0]      state;

  logic [31:0] mem   [NW] = '{default: 32'h0};
  logic [31:0] model [NW] = '{default: 32'h0};

  int n_cmp = 0;
  int n_fail = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  mem_lsu #(.NUMWORDS(NW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_re_o       (mem_re),
    .mem_raddr_o    (mem_raddr),
    .mem_rdata_i    (mem_rdata),
    .mem_we_o       (mem_we),
    .mem_waddr_o    (mem_waddr),
    .mem_wdata_o    (mem_wdata),
    .state_o        (state)
  );

  assign mem_rdata = (mem_raddr < 5'd16) ? mem[mem_raddr[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_waddr < 5'd16) mem[mem_waddr[3:0]] <= mem_wdata;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re && mem_we) both_cnt <= both_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request; keep=1 leaves resp_ready low and req_valid high and returns at the first response cycle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns, input logic [6:0] addr,
                        input logic [31:0] wdata, input logic keep,
                        output logic [31:0] rdata, output logic err, output int lat, output int we_at);
    int t;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    resp_ready = !keep;
    t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
    lat = 1; we_at = 0;
    while (!resp_valid && lat < 20) begin
      if (mem_we) we_at = lat;
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err = resp_err;
    if (!keep) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic req_chk(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [6:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input int exp_we_at, input int exp_re, input int exp_we);
    logic [31:0] rd;
    logic        er;
    int          lat, wat, r0, w0;
    r0 = re_cnt; w0 = we_cnt;
    do_req(we, size, uns, addr, wdata, 1'b0, rd, er, lat, wat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_we_at"}, wat, exp_we_at);
    chk({tag, "_re_pulses"}, re_cnt - r0, exp_re);
    chk({tag, "_we_pulses"}, we_cnt - w0, exp_we);
  endtask

  // Reference behaviour written from the lane description, independent of the RTL datapath.
  task automatic model_op(input logic we, input logic [1:0] size, input logic uns, input logic [6:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic e,
                          output int lat, output int we_at, output int np_re, output int np_we);
    int idx, l;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    idx = int'(addr[6:2]);
    l = int'(addr[1:0]);
    e = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && l != 0) || (idx >= NW);
    rd = 32'h0; lat = 1; we_at = 0; np_re = 0; np_we = 0;
    if (!e) begin
      if (!we) begin
        w = model[idx];
        lat = 2; np_re = 1;
        case (size)
          2'b00: begin b = w[l*8 +: 8];  rd = uns ? {24'h0, b} : {{24{b[7]}}, b}; end
          2'b01: begin h = w[l*8 +: 16]; rd = uns ? {16'h0, h} : {{16{h[15]}}, h}; end
          default: rd = w;
        endcase
      end else if (size == 2'b10) begin
        model[idx] = wdata; lat = 2; we_at = 1; np_we = 1;
      end else begin
        if (size == 2'b00) model[idx][l*8 +: 8] = wdata[7:0];
        else               model[idx][l*8 +: 16] = wdata[15:0];
        lat = 3; we_at = 2; np_re = 1; np_we = 1;
      end
    end
  endtask

  initial begin
    logic [31:0] rd, m_rd;
    logic        er, m_e, r_we, r_uns;
    logic [1:0]  r_size;
    logic [6:0]  r_addr;
    logic [31:0] r_wdata;
    int          lat, wat, m_lat, m_wat, m_re, m_we, r0;

    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'h0; resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_re", {31'h0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_state", {29'h0, state}, {29'h0, LSU_IDLE});
    rst = 1'b0;
    @(posedge clk); #1;

    req_chk("st_w8", 1'b1, SZ_W, 1'b0, 7'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0, 1);
    chk("mem2_after_st_w", mem[2], 32'hDEADBEEF);
    req_chk("ld_w8", 1'b0, SZ_W, 1'b0, 7'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1, 0);
    req_chk("st_b9", 1'b1, SZ_B, 1'b0, 7'h09, 32'h0000007F, 32'h0, 1'b0, 3, 2, 1, 1);
    chk("mem2_after_st_b", mem[2], 32'hDEAD7FEF);
    req_chk("ld_bB_s", 1'b0, SZ_B, 1'b0, 7'h0B, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 1, 0);
    req_chk("ld_bB_u", 1'b0, SZ_B, 1'b1, 7'h0B, 32'h0, 32'h000000DE, 1'b0, 2, 0, 1, 0);
    req_chk("ld_h1_mis", 1'b0, SZ_H, 1'b0, 7'h01, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    req_chk("ld_w40_oor", 1'b0, SZ_W, 1'b0, 7'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    req_chk("st_w40_oor", 1'b1, SZ_W, 1'b0, 7'h40, 32'h11111111, 32'h0, 1'b1, 1, 0, 0, 0);
    req_chk("ld_sz3", 1'b0, 2'b11, 1'b0, 7'h00, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    req_chk("st_w2_mis", 1'b1, SZ_W, 1'b0, 7'h0A, 32'h22222222, 32'h0, 1'b1, 1, 0, 0, 0);
    chk("mem0_untouched", mem[0], 32'h0);
    chk("mem2_untouched", mem[2], 32'hDEAD7FEF);
    req_chk("st_h6", 1'b1, SZ_H, 1'b0, 7'h06, 32'hABCD1234, 32'h0, 1'b0, 3, 2, 1, 1);
    chk("mem1_after_st_h", mem[1], 32'h12340000);
    req_chk("ld_h6_s", 1'b0, SZ_H, 1'b0, 7'h06, 32'h0, 32'h00001234, 1'b0, 2, 0, 1, 0);
    req_chk("ld_hA_s", 1'b0, SZ_H, 1'b0, 7'h0A, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0, 1, 0);

    // Response held off: everything must stay frozen and the pending request must not be taken.
    do_req(1'b0, SZ_H, 1'b1, 7'h0A, 32'h0, 1'b1, rd, er, lat, wat);
    chk("hold_first_rdata", rd, 32'h0000DEAD);
    chk("hold_first_lat", lat, 2);
    r0 = re_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'h0000DEAD);
      chk("hold_err", {31'h0, resp_err}, 32'd0);
      chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
    end
    chk("hold_no_new_read", re_cnt - r0, 0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", {31'h0, resp_valid}, 32'd0);
    chk("hold_release_ready", {31'h0, req_ready}, 32'd1);

    // Reset lands while the sub-word store is in its write cycle.
    req_we = 1'b1; req_size = SZ_B; req_unsigned = 1'b0; req_addr = 7'h04; req_wdata = 32'h00000055;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstwr_we_before", {31'h0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr_we_dropped", {31'h0, mem_we}, 32'd0);
    chk("rstwr_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rstwr_state", {29'h0, state}, {29'h0, LSU_IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstwr_no_resp", {31'h0, resp_valid}, 32'd0);
    end
    chk("rstwr_mem1_intact", mem[1], 32'h12340000);

    // Random requests checked against the lane model, seeded with the memory image built above.
    model[1] = 32'h12340000;
    model[2] = 32'hDEAD7FEF;
    for (int i = 0; i < 8; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_uns = 1'($urandom_range(0, 1));
      r_addr = 7'($urandom_range(0, 75));
      r_wdata = $urandom;
      model_op(r_we, r_size, r_uns, r_addr, r_wdata, m_rd, m_e, m_lat, m_wat, m_re, m_we);
      req_chk($sformatf("rnd%0d", i), r_we, r_size, r_uns, r_addr, r_wdata, m_rd, m_e, m_lat, m_wat, m_re, m_we);
      if (r_we && !m_e) chk($sformatf("rnd%0d_mem", i), mem[r_addr[5:2]], model[r_addr[5:2]]);
    end

    chk("never_re_and_we", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
